// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a qualified lock, then
// releases the downstream reset. Retries on timeout or lock glitches, and
// latches a sticky failure once the retry budget is used up.
module pll_rst_ctrl #(
    parameter int RST_CYCLES   = 100,    // pll_rst high time per attempt
    parameter int LOCK_TIMEOUT = 50000,  // max cycles waiting for lock per attempt
    parameter int LOCK_STABLE  = 1024,   // consecutive lock cycles before release (>= 2)
    parameter int MAX_RETRY    = 7       // retries before declaring failure (1..15)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first stable
    // cycle, so STABLE itself needs LOCK_STABLE-1 more lock_s=1 cycles.
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    retry_nxt;
    logic          retry_evt;
    logic          lock_m, lock_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Next-state, shared counter and retry bookkeeping
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        retry_nxt = retry_cnt;
        retry_evt = 1'b0;
        if (restart) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (lock_s)               state_nxt = STABLE;
                    else if (cnt == TO_LAST)  retry_evt = 1'b1;
                end
                STABLE: begin
                    if (!lock_s)              retry_evt = 1'b1;
                    else if (cnt == STB_LAST) state_nxt = RUN;
                end
                RUN: begin
                    cnt_nxt = cnt;  // idle here; hold rather than wrap
                    if (!lock_s) begin
                        state_nxt = RESET_PLL;  // new episode
                        retry_nxt = '0;
                    end
                end
                FAIL:    cnt_nxt = cnt;
                default: state_nxt = RESET_PLL;
            endcase
            if (retry_evt) begin
                if (retry_cnt >= RETRY_MAX) begin
                    state_nxt = FAIL;
                end else begin
                    state_nxt = RESET_PLL;
                    retry_nxt = retry_cnt + 4'd1;
                end
            end
        end
        if (state_nxt != state) cnt_nxt = '0;
    end

    // State register with outputs decoded from next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
            sys_rst_n <= (state_nxt == RUN);
            ready     <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: stimulus pushes the expected output
// transitions (cycle + value), a monitor pops one on every output change.
module tb_pll_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;   // {pll_rst, sys_rst_n, ready, fail, retry_cnt}
        string      name;
    } ev_t;

    ev_t q[$];

    pll_rst_ctrl #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (8),
        .MAX_RETRY   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic ps, input logic sr, input logic rd,
                             input logic fl, input logic [3:0] rc, input string nm);
        ev_t e;
        e.cyc  = c;
        e.val  = {ps, sr, rd, fl, rc};
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any output change must match the next expected transition
    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        ev_t        e;
        prev = 'x;
        @(posedge clk);
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            cur = {pll_rst, sys_rst_n, ready, fail, retry_cnt};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: no change seen at cycle %0d (now %0d), want %b got %b",
                         e.name, e.cyc, cyc, e.val, cur);
            end
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d got %b (next expected cycle %0d)",
                             cyc, cur, (q.size() > 0) ? q[0].cyc : -1);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.val) begin
                        errors++;
                        $display("FAIL %s: cycle %0d got %b want %b", e.name, cyc, cur, e.val);
                    end
                end
                prev = cur;
            end
        end
    end

    // Directed stimulus; expected transitions hand-computed for
    // RST=4, TIMEOUT=32, STABLE=8, MAX_RETRY=2
    initial begin
        int r, l, d, g, f, j;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        expect_at(1, 1, 0, 0, 0, 0, "reset_state");

        // normal lock
        wait_until(2); r = cyc; rst_n = 1'b1;
        expect_at(r + 4, 0, 0, 0, 0, 0, "pll_rst_4cyc");
        wait_until(r + 10); l = cyc; pll_lock = 1'b1;
        expect_at(l + 10, 0, 1, 1, 0, 0, "lock_latency");

        // lock loss in RUN (retry already 0)
        wait_until(l + 12); d = cyc; pll_lock = 1'b0;
        expect_at(d + 3, 1, 0, 0, 0, 0, "loss_reset");
        expect_at(d + 7, 0, 0, 0, 0, 0, "loss_wait");

        // glitch during STABLE
        wait_until(d + 9); g = cyc; pll_lock = 1'b1;
        expect_at(g + 8,  1, 0, 0, 0, 1, "glitch_retry");
        expect_at(g + 12, 0, 0, 0, 0, 1, "glitch_wait");
        expect_at(g + 20, 0, 1, 1, 0, 1, "glitch_run");
        wait_until(g + 5); pll_lock = 1'b0;
        wait_until(g + 6); pll_lock = 1'b1;

        // lock loss in RUN clears retry_cnt, then relock
        wait_until(g + 22); d = cyc; pll_lock = 1'b0;
        expect_at(d + 3, 1, 0, 0, 0, 0, "run_loss_clr");
        expect_at(d + 7, 0, 0, 0, 0, 0, "run_loss_wait");
        wait_until(d + 9); l = cyc; pll_lock = 1'b1;
        expect_at(l + 10, 0, 1, 1, 0, 0, "relock");

        // async reset between edges while in RUN
        wait_until(l + 12);
        #2;
        expect_at(cyc, 1, 0, 0, 0, 0, "async_rst");
        rst_n    = 1'b0;
        pll_lock = 1'b0;

        // never locks: three 36-cycle attempts then FAIL
        wait_until(l + 14); r = cyc; rst_n = 1'b1;
        expect_at(r + 4,   0, 0, 0, 0, 0, "nl_wait0");
        expect_at(r + 36,  1, 0, 0, 0, 1, "nl_retry1");
        expect_at(r + 40,  0, 0, 0, 0, 1, "nl_wait1");
        expect_at(r + 72,  1, 0, 0, 0, 2, "nl_retry2");
        expect_at(r + 76,  0, 0, 0, 0, 2, "nl_wait2");
        expect_at(r + 108, 1, 0, 0, 1, 2, "nl_fail");

        // restart out of FAIL
        wait_until(r + 112); f = cyc; restart = 1'b1;
        expect_at(f + 1, 1, 0, 0, 0, 0, "restart_clr");
        expect_at(f + 5, 0, 0, 0, 0, 0, "restart_rst4");
        wait_until(f + 1); restart = 1'b0;
        wait_until(f + 7); pll_lock = 1'b1;
        expect_at(f + 17, 0, 1, 1, 0, 0, "restart_run");

        // restart coinciding with synchronized lock drop in RUN
        wait_until(f + 19); j = cyc; pll_lock = 1'b0;
        expect_at(j + 3, 1, 0, 0, 0, 0, "restart_and_loss");
        expect_at(j + 7, 0, 0, 0, 0, 0, "restart_and_loss_wait");
        wait_until(j + 2); restart = 1'b1;
        wait_until(j + 3); restart = 1'b0;

        // restart beats a STABLE glitch retry in the same cycle
        wait_until(j + 7);  pll_lock = 1'b1;
        wait_until(j + 10); pll_lock = 1'b0;
        wait_until(j + 11); pll_lock = 1'b1;
        wait_until(j + 12); restart = 1'b1;
        expect_at(j + 13, 1, 0, 0, 0, 0, "restart_prio");
        expect_at(j + 17, 0, 0, 0, 0, 0, "restart_prio_wait");
        expect_at(j + 25, 0, 1, 1, 0, 0, "final_run");
        wait_until(j + 13); restart = 1'b0;

        wait_until(j + 30);
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected change at cycle %0d never checked", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 100, cycles pll_rst is held high per attempt (2 us at 50 MHz).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, max cycles waiting for lock per attempt.
REQ-003 SHALL have parameter LOCK_STABLE, default 1024, consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 7, range 1..15, retries allowed before declaring failure.
REQ-005 SHALL have port: clk  input  1  free-running PLL reference clock (same net as PLL clkin1).
REQ-006 SHALL have port: rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port: pll_lock  input  1  PLL lock, asynchronous to clk.
REQ-008 SHALL have port: restart  input  1  synchronous single-cycle request to re-run the lock sequence.
REQ-009 SHALL have port: pll_rst  output  1  active-high PLL reset.
REQ-010 SHALL have port: sys_rst_n  output  1  active-low reset for logic on PLL output clocks.
REQ-011 SHALL have port: ready  output  1  high only while PLL locked and released.
REQ-012 SHALL have port: fail  output  1  sticky lock-failure flag.
REQ-013 SHALL have port: retry_cnt  output  4  retries consumed in current episode.

Function
REQ-014 SHALL synchronize pll_lock through two clk flops (lock_s); all decisions use lock_s only.
REQ-015 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL with one shared counter, cleared on every state change.
REQ-016 RESET_PLL: pll_rst=1; after RST_CYCLES cycles -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry event.
REQ-018 STABLE: lock_s=1 for LOCK_STABLE consecutive cycles -> RUN; lock_s=0 at any cycle -> retry event.
REQ-019 Retry event: retry_cnt==MAX_RETRY -> FAIL; else retry_cnt+1 and -> RESET_PLL.
REQ-020 RUN: sys_rst_n=1, ready=1, retry_cnt held; lock_s=0 -> RESET_PLL with retry_cnt cleared to 0 (new episode), sys_rst_n=0 and ready=0 on the next edge.
REQ-021 FAIL: pll_rst=1, sys_rst_n=0, ready=0, fail=1; remains until restart or rst_n.
REQ-022 restart=1 in any state -> RESET_PLL, counter=0, retry_cnt=0, fail=0; takes priority over all other transitions in the same cycle.
REQ-023 All outputs SHALL be registered and Moore-decoded from state: pll_rst=1 in RESET_PLL/FAIL; sys_rst_n=ready=1 only in RUN.
REQ-024 Latency: sys_rst_n rises exactly LOCK_STABLE+2 cycles after the pll_lock rising edge sampled in WAIT_LOCK (2 sync + LOCK_STABLE).
REQ-025 Counter width SHALL be derived from max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE); no wrap permitted.
REQ-026 pll_lock already high on entry to WAIT_LOCK SHALL be treated as a lock (-> STABLE next cycle).

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state RESET_PLL, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0, retry_cnt=0, sync flops=0.
REQ-028 After rst_n deassertion, the first rising edge SHALL begin RESET_PLL counting; rst_n assertion mid-sequence SHALL abort to REQ-027 values immediately.

Verification (bench params RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=2)
REQ-029 Normal lock: rst_n release, pll_lock rises 10 cycles later -> pll_rst high exactly 4 cycles; sys_rst_n/ready rise exactly 10 cycles after pll_lock edge; retry_cnt=0.
REQ-030 Never locks: pll_lock=0 -> three attempts of 36 cycles each; retry_cnt 0->1->2; fail=1 and pll_rst=1 at cycle 108 after release; sys_rst_n stays 0.
REQ-031 Glitch in STABLE: pll_lock high 5 cycles, low 1, high again -> retry_cnt=1, pll_rst reasserted 4 cycles, then normal release.
REQ-032 Lock loss in RUN: drop pll_lock -> sys_rst_n=0, ready=0 within 3 cycles, retry_cnt=0, pll_rst high 4 cycles, relock on pll_lock return.
REQ-033 Restart from FAIL: pulse restart -> fail=0, retry_cnt=0, pll_rst high 4 cycles next; restart and lock drop in same cycle -> restart behaviour.
REQ-034 Async reset in RUN: rst_n low between edges -> sys_rst_n=0, pll_rst=1 before next clk edge.
